// File: rtl/puf_pkg.sv
// Shared definitions for the PUF response path. The PUF wrapper imports
// these too, so address/data widths stay in one place.
package puf_pkg;

  localparam int PUF_ADDR_W = 4;
  localparam int PUF_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    EMIT
  } state_t;

endpackage

// File: rtl/puf_bit_voter.sv
// Per-bit vote counters for one PUF address. The outputs already include
// the sample currently on i_data, so the final vote is ready in the same
// cycle the last sample arrives and the reader can latch it immediately.
module puf_bit_voter
  import puf_pkg::*;
#(
  parameter int VOTES = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_clear,
  input  logic                  i_accumulate,
  input  logic [PUF_DATA_W-1:0] i_data,
  output logic [PUF_DATA_W-1:0] o_voted,
  output logic                  o_flaky
);

  localparam int CNT_W = $clog2(VOTES + 1);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(VOTES / 2);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(VOTES);

  logic [CNT_W-1:0] r_cnt [PUF_DATA_W];
  logic [CNT_W-1:0] w_sum [PUF_DATA_W];

  // Running totals including the present sample, majority and disagreement
  always_comb begin
    o_voted = '0;
    o_flaky = 1'b0;
    for (int i = 0; i < PUF_DATA_W; i++) begin
      w_sum[i]   = r_cnt[i] + CNT_W'(i_data[i]);
      o_voted[i] = (w_sum[i] > HALF);
      if ((w_sum[i] != '0) && (w_sum[i] != FULL)) begin
        o_flaky = 1'b1;
      end
    end
  end

  // Counters clear before each address and add one sample per cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PUF_DATA_W; i++) r_cnt[i] <= '0;
    end else if (i_clear) begin
      for (int i = 0; i < PUF_DATA_W; i++) r_cnt[i] <= '0;
    end else if (i_accumulate) begin
      for (int i = 0; i < PUF_DATA_W; i++) r_cnt[i] <= w_sum[i];
    end
  end

endmodule

// File: rtl/puf_response_reader.sv
// Sweeps PUF addresses 0..15, lets each response settle, takes VOTES
// samples, and streams one majority-voted byte per address over
// valid/ready. All outputs come from registers, so out_ready never
// reaches an output combinationally.
module puf_response_reader
  import puf_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int VOTES         = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  output logic                  puf_en,
  output logic [PUF_ADDR_W-1:0] puf_addr,
  input  logic [PUF_DATA_W-1:0] puf_data,
  output logic [PUF_DATA_W-1:0] out_data,
  output logic [PUF_ADDR_W-1:0] out_addr,
  output logic                  out_flaky,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);

  localparam logic [7:0]            SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
  localparam logic [3:0]            SAMPLE_LAST = 4'(VOTES - 1);
  localparam logic [PUF_ADDR_W-1:0] LAST_ADDR   = '1;

  state_t                r_state;
  state_t                w_nextState;
  logic [7:0]            r_settle;
  logic [3:0]            r_samples;
  logic [PUF_ADDR_W-1:0] r_addr;
  logic [PUF_DATA_W-1:0] r_outData;
  logic [PUF_ADDR_W-1:0] r_outAddr;
  logic                  r_outFlaky;
  logic                  r_done;

  logic                  w_handshake;
  logic                  w_begin;
  logic                  w_clear;
  logic                  w_accumulate;
  logic                  w_latch;
  logic                  w_advance;
  logic                  w_finish;
  logic [PUF_DATA_W-1:0] w_voted;
  logic                  w_flaky;

  assign w_handshake = (r_state == EMIT) && out_ready;

  puf_bit_voter #(
    .VOTES(VOTES)
  ) u_voter (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (w_clear),
    .i_accumulate(w_accumulate),
    .i_data      (puf_data),
    .o_voted     (w_voted),
    .o_flaky     (w_flaky)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  // Next state and one-cycle control strobes; abort overrides everything
  always_comb begin
    w_nextState  = r_state;
    w_begin      = 1'b0;
    w_clear      = 1'b0;
    w_accumulate = 1'b0;
    w_latch      = 1'b0;
    w_advance    = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_begin     = 1'b1;
          w_nextState = SETTLE;
        end
      end
      SETTLE: begin
        if (r_settle == '0) begin
          w_clear     = 1'b1;
          w_nextState = SAMPLE;
        end
      end
      SAMPLE: begin
        w_accumulate = 1'b1;
        if (r_samples == SAMPLE_LAST) begin
          w_latch     = 1'b1;
          w_nextState = EMIT;
        end
      end
      EMIT: begin
        if (w_handshake) begin
          if (r_addr == LAST_ADDR) begin
            w_finish    = 1'b1;
            w_nextState = IDLE;
          end else begin
            w_advance   = 1'b1;
            w_nextState = SETTLE;
          end
        end
      end
      default: w_nextState = IDLE;
    endcase
    if (abort) begin
      w_nextState  = IDLE;
      w_begin      = 1'b0;
      w_clear      = 1'b0;
      w_accumulate = 1'b0;
      w_latch      = 1'b0;
      w_advance    = 1'b0;
      w_finish     = 1'b0;
    end
  end

  // Address, settle/sample counters, output byte and done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_settle   <= '0;
      r_samples  <= '0;
      r_addr     <= '0;
      r_outData  <= '0;
      r_outAddr  <= '0;
      r_outFlaky <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_begin) begin
        r_addr   <= '0;
        r_settle <= SETTLE_LOAD;
      end else if (w_advance) begin
        r_addr   <= r_addr + 4'd1;
        r_settle <= SETTLE_LOAD;
      end else if ((r_state == SETTLE) && (r_settle != '0)) begin
        r_settle <= r_settle - 8'd1;
      end
      if (w_clear) begin
        r_samples <= '0;
      end else if (w_accumulate) begin
        r_samples <= r_samples + 4'd1;
      end
      if (w_latch) begin
        r_outData  <= w_voted;
        r_outAddr  <= r_addr;
        r_outFlaky <= w_flaky;
      end
    end
  end

  assign busy      = (r_state != IDLE);
  assign puf_en    = busy;
  assign out_valid = (r_state == EMIT);
  assign puf_addr  = r_addr;
  assign out_data  = r_outData;
  assign out_addr  = r_outAddr;
  assign out_flaky = r_outFlaky;
  assign done      = r_done;

endmodule

// File: tb/tb_puf_response_reader.sv
// Bench for puf_response_reader: randomized PUF samples, ready and
// control hazards, compared every cycle against a sweep-level model.
module tb_puf_response_reader;

  localparam int S = 4;
  localparam int V = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic       out_ready;
  logic [7:0] puf_data;
  logic       puf_en;
  logic [3:0] puf_addr;
  logic [7:0] out_data;
  logic [3:0] out_addr;
  logic       out_flaky;
  logic       out_valid;
  logic       busy;
  logic       done;

  puf_response_reader #(
    .SETTLE_CYCLES(S),
    .VOTES        (V)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .puf_en   (puf_en),
    .puf_addr (puf_addr),
    .puf_data (puf_data),
    .out_data (out_data),
    .out_addr (out_addr),
    .out_flaky(out_flaky),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy),
    .done     (done)
  );

  // Free-running clock
  always #5 clk = ~clk;

  int checkCount = 0;
  int passCount  = 0;

  bit         mActive;
  bit         mDone;
  int         mAddr;
  int         mK;
  logic [7:0] mSamples [V];

  bit noisyMode;
  bit directedNoise;
  bit abortWithStart;
  int readyPct;
  int startPct;
  int holdAddr;
  int holdLeft;
  int abortAddr;

  int cyc;
  int firstRise;
  int secondRise;
  bit prevValid;
  int hsSeen;
  int doneSeen;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  function automatic logic [8:0] voteOf();
    logic [8:0] r;
    int ones;
    r = '0;
    for (int b = 0; b < 8; b++) begin
      ones = 0;
      for (int s = 0; s < V; s++) ones += int'(mSamples[s][b]);
      if (2 * ones > V) r[b] = 1'b1;
      if (ones != 0 && ones != V) r[8] = 1'b1;
    end
    return r;
  endfunction

  task automatic genSamples();
    logic [7:0] base;
    logic [3:0] a;
    a = mAddr[3:0];
    base = noisyMode ? 8'($urandom) : {a, ~a};
    for (int s = 0; s < V; s++) begin
      mSamples[s] = base;
      if (noisyMode && $urandom_range(0, 2) == 0) mSamples[s] = base ^ 8'($urandom);
    end
    if (directedNoise && mAddr == 3) begin
      mSamples[0] = 8'hA5;
      mSamples[1] = 8'hA5;
      mSamples[2] = 8'h5A;
    end
  endtask

  task automatic modelStep(input bit pStart, input bit pAbort, input bit pReady);
    mDone = 1'b0;
    if (pAbort) begin
      mActive = 1'b0;
    end else if (!mActive) begin
      if (pStart) begin
        mActive = 1'b1;
        mAddr   = 0;
        mK      = 0;
        genSamples();
      end
    end else if (mK == S + V) begin
      if (pReady) begin
        if (mAddr == 15) begin
          mActive = 1'b0;
          mDone   = 1'b1;
        end else begin
          mAddr++;
          mK = 0;
          genSamples();
        end
      end
    end else begin
      mK++;
    end
  endtask

  task automatic compareAll();
    bit         expValid;
    logic [8:0] v;
    expValid = mActive && (mK == S + V);
    checkOutput("busy", 32'(busy), 32'(mActive));
    checkOutput("puf_en", 32'(puf_en), 32'(mActive));
    checkOutput("puf_addr", 32'(puf_addr), 32'(mAddr));
    checkOutput("out_valid", 32'(out_valid), 32'(expValid));
    checkOutput("done", 32'(done), 32'(mDone));
    if (expValid) begin
      v = voteOf();
      checkOutput("out_data", 32'(out_data), 32'(v[7:0]));
      checkOutput("out_addr", 32'(out_addr), 32'(mAddr));
      checkOutput("out_flaky", 32'(out_flaky), 32'(v[8]));
    end
  endtask

  task automatic drivePuf();
    if (mActive && mK >= S && mK < S + V) puf_data = mSamples[mK - S];
    else                                  puf_data = 8'($urandom);
  endtask

  task automatic applyStimulus();
    start     = 1'b0;
    abort     = 1'b0;
    out_ready = ($urandom_range(1, 100) <= readyPct);
    if (mActive && mK == S + V && mAddr == holdAddr && holdLeft > 0) begin
      out_ready = 1'b0;
      holdLeft--;
    end
    if (mActive && $urandom_range(1, 100) <= startPct) start = 1'b1;
    if (mActive && mAddr == abortAddr && mK == 2) begin
      abort = 1'b1;
      start = abortWithStart;
    end
    drivePuf();
  endtask

  task automatic runCycle();
    bit pStart, pAbort, pReady, wasActive;
    pStart    = start;
    pAbort    = abort;
    pReady    = out_ready;
    wasActive = mActive;
    @(posedge clk);
    #1;
    modelStep(pStart, pAbort, pReady);
    if (!wasActive && mActive) cyc = 1;
    else cyc++;
    if (prevValid && pReady && !pAbort) hsSeen++;
    if (out_valid && !prevValid) begin
      if (firstRise < 0) firstRise = cyc;
      else if (secondRise < 0) secondRise = cyc;
    end
    prevValid = out_valid;
    if (done) doneSeen++;
    compareAll();
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus();
      runCycle();
    end
  endtask

  task automatic doSweep(input int budget, input int resetAtAddr);
    applyStimulus();
    start = 1'b1;
    abort = 1'b0;
    runCycle();
    for (int n = 0; n < budget && mActive; n++) begin
      if (mActive && mAddr == resetAtAddr && mK == S + 1) begin
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("rstMid_busy", 32'(busy), 0);
        checkOutput("rstMid_puf_en", 32'(puf_en), 0);
        checkOutput("rstMid_puf_addr", 32'(puf_addr), 0);
        checkOutput("rstMid_out_data", 32'(out_data), 0);
        checkOutput("rstMid_out_addr", 32'(out_addr), 0);
        checkOutput("rstMid_out_flaky", 32'(out_flaky), 0);
        checkOutput("rstMid_out_valid", 32'(out_valid), 0);
        checkOutput("rstMid_done", 32'(done), 0);
        mActive   = 1'b0;
        mAddr     = 0;
        mK        = 0;
        prevValid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        abort = 1'b0;
      end else begin
        applyStimulus();
        runCycle();
      end
    end
    checkOutput("sweepTimeout", 32'(mActive), 0);
    mActive = 1'b0;
  endtask

  task automatic resetTrackers();
    firstRise  = -1;
    secondRise = -1;
    hsSeen     = 0;
    doneSeen   = 0;
  endtask

  // Main sequence: reset, clean sweep, noisy/backpressured sweep, abort, restart, reset mid-sample
  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0; puf_data = 8'h00;
    mActive = 1'b0; mDone = 1'b0; mAddr = 0; mK = 0; prevValid = 1'b0; cyc = 0;
    noisyMode = 1'b0; directedNoise = 1'b0; abortWithStart = 1'b0;
    readyPct = 100; startPct = 0; holdAddr = -1; holdLeft = 0; abortAddr = -1;
    resetTrackers();
    #12;
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_puf_en", 32'(puf_en), 0);
    checkOutput("rst_puf_addr", 32'(puf_addr), 0);
    checkOutput("rst_out_data", 32'(out_data), 0);
    checkOutput("rst_out_addr", 32'(out_addr), 0);
    checkOutput("rst_out_flaky", 32'(out_flaky), 0);
    checkOutput("rst_out_valid", 32'(out_valid), 0);
    checkOutput("rst_done", 32'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idleCycles(3);

    $display("[TB] stable sweep");
    resetTrackers();
    doSweep(1000, -1);
    checkOutput("latFirst", 32'(firstRise), 8);
    checkOutput("latSecond", 32'(secondRise), 16);
    checkOutput("handshakes", 32'(hsSeen), 16);
    checkOutput("donePulses", 32'(doneSeen), 1);
    idleCycles(3);

    $display("[TB] noisy sweep with backpressure and start while busy");
    noisyMode = 1'b1; directedNoise = 1'b1; startPct = 15;
    holdAddr = 9; holdLeft = 10;
    resetTrackers();
    doSweep(1000, -1);
    checkOutput("holdConsumed", 32'(holdLeft), 0);
    checkOutput("handshakes2", 32'(hsSeen), 16);
    checkOutput("donePulses2", 32'(doneSeen), 1);
    idleCycles(3);

    $display("[TB] abort at address 7 with simultaneous start");
    directedNoise = 1'b0; holdAddr = -1; readyPct = 60; startPct = 10;
    abortAddr = 7; abortWithStart = 1'b1;
    resetTrackers();
    doSweep(1000, -1);
    idleCycles(4);
    checkOutput("abortNoDone", 32'(doneSeen), 0);
    checkOutput("abortHandshakes", 32'(hsSeen), 7);

    $display("[TB] restart after abort");
    abortAddr = -1; readyPct = 70;
    resetTrackers();
    doSweep(1000, -1);
    checkOutput("restartDone", 32'(doneSeen), 1);
    idleCycles(3);

    $display("[TB] reset during sampling");
    readyPct = 100; startPct = 0;
    doSweep(1000, 5);
    idleCycles(3);
    resetTrackers();
    doSweep(1000, -1);
    checkOutput("postResetDone", 32'(doneSeen), 1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
